// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the 554 CPU program-counter unit.
//   pc_mode_t  - 3-bit update mode, fully decoded (all eight codes legal).
//   is_redirect - true for modes that move the PC somewhere other than
//                 "stay" or "next sequential" (used by the trace option).
package pc_pkg;

  typedef enum logic [2:0] {
    PC_STALL     = 3'b000,
    PC_NORMAL    = 3'b001,
    PC_REGISTER  = 3'b010,
    PC_IMMEDIATE = 3'b011,
    PC_RELATIVE  = 3'b100,
    PC_CALL_IMM  = 3'b101,
    PC_CALL_REG  = 3'b110,
    PC_RETURN    = 3'b111
  } pc_mode_t;

  function automatic logic is_redirect(input pc_mode_t mode);
    return (mode != PC_STALL) && (mode != PC_NORMAL);
  endfunction

endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address LIFO.
//   Push writes at tos+1 and advances tos; pushing while full overwrites
//   the oldest entry and sets the sticky ovf flag. Pop retreats tos.
//   Ports:
//     clk, rst   - clock, synchronous active-high reset (pointer/count/ovf)
//     push, pop  - mutually exclusive requests from the owner
//     din        - address to push
//     top        - entry at tos (valid when not empty)
//     count      - number of valid entries, saturates at DEPTH
//     full/empty - decoded from count
//     ovf        - sticky, set when a push overwrote the oldest entry
module ras_stack #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             top,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] tos;
  logic [AW-1:0] tos_inc;

  assign tos_inc = tos + 1'b1;
  assign top     = mem[tos];
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);

  // Control state: pointer, occupancy and overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      tos   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (push) begin
      tos <= tos_inc;
      if (full) ovf   <= 1'b1;  // oldest entry silently overwritten
      else      count <= count + 1'b1;
    end else if (pop && !empty) begin
      tos   <= tos - 1'b1;
      count <= count - 1'b1;
    end
  end

  // Storage is not reset; entries are only read while counted as valid
  always_ff @(posedge clk) begin
    if (push) mem[tos_inc] <= din;
  end

endmodule

// File: rtl/pc_ras.sv
// pc_ras: fetch-stage program counter with integrated return-address stack.
//   Optional build macro PC_RAS_TRACE_EN adds prev_pc / redirect outputs.
//   Ports:
//     clk, rst    - clock, synchronous active-high reset
//     pc_mode     - update mode (pc_pkg::pc_mode_t encoding)
//     reg_in      - register-sourced target (also RETURN fallback)
//     imm_in      - immediate target or signed PC-relative offset
//     pc          - current PC
//     ras_count   - valid RAS entries
//     ras_full    - ras_count == RAS_DEPTH
//     ras_empty   - ras_count == 0
//     ras_ovf     - sticky: a call overwrote the oldest RAS entry
//     ras_unf     - registered pulse: RETURN executed with an empty RAS
//     prev_pc     - (trace) pc value before the most recent edge
//     redirect    - (trace) previous update was not STALL/NORMAL
module pc_ras
  import pc_pkg::*;
#(
  parameter int              PC_W      = 32,
  parameter int              INC       = 1,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter int              RAS_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [2:0]                   pc_mode,
  input  logic [PC_W-1:0]              reg_in,
  input  logic [PC_W-1:0]              imm_in,
  output logic [PC_W-1:0]              pc,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_full,
  output logic                         ras_empty,
  output logic                         ras_ovf,
  output logic                         ras_unf
`ifdef PC_RAS_TRACE_EN
  ,
  output logic [PC_W-1:0]              prev_pc,
  output logic                         redirect
`endif
);

  localparam logic [PC_W-1:0] INC_V = PC_W'(INC);

  pc_mode_t               mode;
  logic [PC_W-1:0]        pc_next;
  logic [PC_W-1:0]        link;
  logic signed [PC_W-1:0] rel_sum;
  logic [PC_W-1:0]        ras_top;
  logic                   push;
  logic                   pop;

  assign mode    = pc_mode_t'(pc_mode);
  assign link    = pc + INC_V;
  assign rel_sum = $signed(pc) + $signed(imm_in);

  always_comb begin
    pc_next = pc;
    push    = 1'b0;
    pop     = 1'b0;
    unique case (mode)
      PC_STALL:     pc_next = pc;
      PC_NORMAL:    pc_next = link;
      PC_REGISTER:  pc_next = reg_in;
      PC_IMMEDIATE: pc_next = imm_in;
      PC_RELATIVE:  pc_next = $unsigned(rel_sum);
      PC_CALL_IMM: begin
        pc_next = imm_in;
        push    = 1'b1;
      end
      PC_CALL_REG: begin
        pc_next = reg_in;
        push    = 1'b1;
      end
      PC_RETURN: begin
        // Empty stack falls back to the software-maintained link register
        if (!ras_empty) begin
          pc_next = ras_top;
          pop     = 1'b1;
        end else begin
          pc_next = reg_in;
        end
      end
      default:      pc_next = pc;
    endcase
  end

  ras_stack #(
    .W     (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (link),
    .top   (ras_top),
    .count (ras_count),
    .full  (ras_full),
    .empty (ras_empty),
    .ovf   (ras_ovf)
  );

  // PC register and underflow pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_VEC;
      ras_unf <= 1'b0;
    end else begin
      pc      <= pc_next;
      ras_unf <= (mode == PC_RETURN) && ras_empty;
    end
  end

`ifdef PC_RAS_TRACE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_pc  <= RESET_VEC;
      redirect <= 1'b0;
    end else begin
      prev_pc  <= pc;
      redirect <= is_redirect(mode);
    end
  end
`endif

endmodule

// File: tb/tb_pc_ras.sv
// tb_pc_ras: directed plus randomized bench for pc_ras. A queue-based
// reference model tracks pc and the return-address stack; a compare
// process checks every output on each falling edge, and directed
// sequences add literal expectations.
module tb_pc_ras;

  localparam int          PC_W  = 32;
  localparam int          DEPTH = 8;
  localparam logic [31:0] RV    = 32'h100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  pc_mode = 3'd0;
  logic [31:0] reg_in = '0;
  logic [31:0] imm_in = '0;
  logic [31:0] pc;
  logic [3:0]  ras_count;
  logic        ras_full, ras_empty, ras_ovf, ras_unf;
`ifdef PC_RAS_TRACE_EN
  logic [31:0] prev_pc;
  logic        redirect;
`endif

  pc_ras #(.PC_W(PC_W), .INC(1), .RESET_VEC(RV), .RAS_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .pc_mode   (pc_mode),
    .reg_in    (reg_in),
    .imm_in    (imm_in),
    .pc        (pc),
    .ras_count (ras_count),
    .ras_full  (ras_full),
    .ras_empty (ras_empty),
    .ras_ovf   (ras_ovf),
    .ras_unf   (ras_unf)
`ifdef PC_RAS_TRACE_EN
    ,
    .prev_pc   (prev_pc),
    .redirect  (redirect)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pc value, stack as a queue (back = newest)
  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  logic        m_ovf, m_unf;
  bit          m_valid = 0;

  always @(posedge clk) begin
    logic [31:0] nxt;
    if (rst) begin
      m_pc = RV; m_q.delete(); m_ovf = 0; m_unf = 0; m_valid = 1;
    end else begin
      nxt   = m_pc;
      m_unf = 0;
      case (pc_mode)
        3'd0: nxt = m_pc;
        3'd1: nxt = m_pc + 1;
        3'd2: nxt = reg_in;
        3'd3: nxt = imm_in;
        3'd4: nxt = m_pc + imm_in;
        3'd5, 3'd6: begin
          m_q.push_back(m_pc + 1);
          if (m_q.size() > DEPTH) begin
            void'(m_q.pop_front());
            m_ovf = 1;
          end
          nxt = (pc_mode == 3'd5) ? imm_in : reg_in;
        end
        default: begin
          if (m_q.size() > 0) nxt = m_q.pop_back();
          else begin
            nxt   = reg_in;
            m_unf = 1;
          end
        end
      endcase
      m_pc = nxt;
    end
  end

  // Compare process
  always @(negedge clk) begin
    if (m_valid) begin
      check("pc", pc, m_pc);
      check("ras_count", 32'(ras_count), 32'(m_q.size()));
      check("ras_full", 32'(ras_full), 32'(m_q.size() == DEPTH));
      check("ras_empty", 32'(ras_empty), 32'(m_q.size() == 0));
      check("ras_ovf", 32'(ras_ovf), 32'(m_ovf));
      check("ras_unf", 32'(ras_unf), 32'(m_unf));
    end
  end

  // Apply one cycle of inputs; returns after the following falling edge
  task automatic step(input logic [2:0] m, input logic [31:0] r, input logic [31:0] i);
    pc_mode = m; reg_in = r; imm_in = i;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    // Reset
    rst = 1'b1;
    step(3'd1, 32'h0, 32'h0);
    rst = 1'b0;
    check("rst_pc", pc, 32'h100);
    check("rst_count", 32'(ras_count), 0);
    check("rst_empty", 32'(ras_empty), 1);
    check("rst_ovf", 32'(ras_ovf), 0);

    // Sequencing
    step(3'd2, 32'h10, 0);
    check("seq_load", pc, 32'h10);
    step(3'd1, 0, 0); check("seq_n1", pc, 32'h11);
    step(3'd1, 0, 0); check("seq_n2", pc, 32'h12);
    step(3'd1, 0, 0); check("seq_n3", pc, 32'h13);
    step(3'd0, 0, 0); check("seq_s1", pc, 32'h13);
    step(3'd0, 0, 0); check("seq_s2", pc, 32'h13);
    step(3'd4, 0, 32'hFFFF_FFFE); check("seq_rel", pc, 32'h11);
    step(3'd3, 0, 32'h1234); check("seq_imm", pc, 32'h1234);

    // Call / return
    step(3'd2, 32'h20, 0);
    step(3'd5, 0, 32'h400);
    check("call_imm_pc", pc, 32'h400); check("call_imm_cnt", 32'(ras_count), 1);
    step(3'd6, 32'h800, 0);
    check("call_reg_pc", pc, 32'h800); check("call_reg_cnt", 32'(ras_count), 2);
    step(3'd7, 32'hdead, 0); check("ret1_pc", pc, 32'h401);
    step(3'd7, 32'hdead, 0); check("ret2_pc", pc, 32'h21);
    check("ret2_empty", 32'(ras_empty), 1);

    // Overflow
    for (int k = 0; k < 9; k++) begin
      step(3'd2, 32'(k), 0);
      step(3'd5, 0, 32'h3000);
    end
    check("ovf_full", 32'(ras_full), 1);
    check("ovf_flag", 32'(ras_ovf), 1);
    check("ovf_cnt", 32'(ras_count), 8);
    for (int k = 0; k < 8; k++) begin
      step(3'd7, 32'h55, 0);
      check("ovf_ret", pc, 32'(9 - k));
      check("ovf_unf_low", 32'(ras_unf), 0);
    end
    step(3'd7, 32'h55, 0);
    check("unf_pc", pc, 32'h55);
    check("unf_pulse", 32'(ras_unf), 1);
    step(3'd0, 0, 0);
    check("unf_drop", 32'(ras_unf), 0);
    check("ovf_sticky", 32'(ras_ovf), 1);

    // Wrap
    step(3'd2, 32'hFFFF_FFFF, 0);
    step(3'd1, 0, 0); check("wrap_normal", pc, 32'h0);
    step(3'd2, 32'hFFFF_FFFF, 0);
    step(3'd5, 0, 32'h77); check("wrap_call", pc, 32'h77);
    step(3'd7, 0, 0); check("wrap_link", pc, 32'h0);

    // Reset in the middle of a RETURN
    step(3'd5, 0, 32'h10);
    step(3'd5, 0, 32'h20);
    step(3'd5, 0, 32'h30);
    check("mid_cnt", 32'(ras_count), 3);
    rst = 1'b1;
    step(3'd7, 32'h99, 0);
    rst = 1'b0;
    check("mid_pc", pc, RV);
    check("mid_cnt0", 32'(ras_count), 0);
    check("mid_unf", 32'(ras_unf), 0);
    check("mid_ovf", 32'(ras_ovf), 0);
    step(3'd0, 0, 0);
    check("mid_unf2", 32'(ras_unf), 0);

    // Randomized traffic, biased toward calls/returns
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] m;
      int sel;
      sel = $urandom_range(0, 15);
      if (sel < 4)       m = 3'd5 + 3'($urandom_range(0, 1));
      else if (sel < 7)  m = 3'd7;
      else               m = 3'($urandom_range(0, 7));
      rst = ($urandom_range(0, 199) == 0);
      step(m, $urandom, ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom);
    end
    rst = 1'b0;
    step(3'd0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
